// File: rtl/exu_alu_sched_pkg.sv
// Shared types for the secondary-ALU scheduler: the ALU predecode packet, the
// queued issue entry, and a predicate for branch/jump predecodes.
package swerv_types;

  // ALU predecode packet carried alongside each operand pair.
  typedef struct packed {
    logic valid;
    logic land;
    logic lor;
    logic lxor;
    logic sll;
    logic srl;
    logic sra;
    logic beq;
    logic bne;
    logic blt;
    logic bge;
    logic add;
    logic sub;
    logic slt;
    logic unsign;
    logic jal;
    logic predict_t;
    logic predict_nt;
    logic csr_write;
    logic csr_imm;
  } alu_pkt_t;

  // One queued ALU operation as held in a requester FIFO.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:1] pc;
    logic [12:1] brimm;
    alu_pkt_t    ap;
  } alu_sched_entry_t;

  // True when the predecode describes a conditional branch or a jump.
  function automatic logic is_branch(alu_pkt_t ap);
    return ap.beq | ap.bne | ap.blt | ap.bge | ap.jal;
  endfunction

endpackage

// File: rtl/exu_alu_sched_fifo.sv
// Per-requester issue FIFO for exu_alu_sched. DEPTH entries (power of 2), registered
// count, flush empties the queue. Push while full and pop while empty are ignored.
module exu_alu_sched_fifo
  import swerv_types::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  alu_sched_entry_t             wdata_i,
  input  logic                         pop_i,
  output alu_sched_entry_t             head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  alu_sched_entry_t mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Pointer and occupancy next state; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PtrW'(push_ok);
      rd_ptr_d = rd_ptr_q + PtrW'(pop_ok);
      cnt_d    = cnt_q + CntW'(push_ok) - CntW'(pop_ok);
    end
  end

  // State registers and entry storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push_ok && !flush_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
      end
    end
  end

endmodule

// File: rtl/exu_alu_sched.sv
// Shares one exu_alu_ctl datapath between NREQ requesters. Each requester feeds a
// small FIFO; a round-robin arbiter issues one op per cycle and the one-cycle
// in-flight owner receives the ALU result and branch flush.
// Optional: define RV_ALU_SCHED_BR_PRIO_EN to let branch/jump heads beat other heads
// (round-robin still applies inside the winning class).
module exu_alu_sched
  import swerv_types::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       freeze,
  input  logic                       flush,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][31:0]      req_a,
  input  logic [NREQ-1:0][31:0]      req_b,
  input  logic [NREQ-1:0][31:1]      req_pc,
  input  logic [NREQ-1:0][12:1]      req_brimm,
  input  alu_pkt_t [NREQ-1:0]        req_ap,
  output logic                       alu_valid,
  output logic                       alu_enable,
  output logic [31:0]                alu_a,
  output logic [31:0]                alu_b,
  output logic [31:1]                alu_pc,
  output logic [12:1]                alu_brimm,
  output alu_pkt_t                   alu_ap,
  input  logic [31:0]                alu_out,
  input  logic                       alu_flush_upper,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [31:0]                rsp_data,
  output logic                       rsp_flush
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  alu_sched_entry_t             fifo_wdata [NREQ];
  alu_sched_entry_t             fifo_head  [NREQ];
  logic [NREQ-1:0]              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [NREQ-1:0][CntW-1:0]    fifo_count;
  logic                         unused_count;

  logic [IdxW-1:0]              rr_q, rr_d;
  logic                         inf_vld_q, inf_vld_d;
  logic [IdxW-1:0]              owner_q, owner_d;

  logic [NREQ-1:0]              cand;
  logic                         grant_vld;
  logic [IdxW-1:0]              grant_idx;
  int                           idx;
  logic [IdxW-1:0]              idx_l;
  logic                         issue;
  logic                         rsp_fire;
  alu_sched_entry_t             head_sel;

  // Occupancy is only consumed through full/empty.
  assign unused_count = ^fifo_count;

  for (genvar g = 0; g < int'(NREQ); g++) begin : g_req
    assign fifo_wdata[g] = '{a: req_a[g], b: req_b[g], pc: req_pc[g],
                             brimm: req_brimm[g], ap: req_ap[g]};
    // Flush drops the same-cycle enqueue.
    assign fifo_push[g]  = req_valid[g] & req_ready[g] & ~flush;
    assign fifo_pop[g]   = issue & (grant_idx == IdxW'(g));
    assign req_ready[g]  = ~fifo_full[g];

    exu_alu_sched_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .flush_i (flush),
      .push_i  (fifo_push[g]),
      .wdata_i (fifo_wdata[g]),
      .pop_i   (fifo_pop[g]),
      .head_o  (fifo_head[g]),
      .count_o (fifo_count[g]),
      .full_o  (fifo_full[g]),
      .empty_o (fifo_empty[g])
    );
  end

`ifdef RV_ALU_SCHED_BR_PRIO_EN
  logic [NREQ-1:0] br_head;
`endif

  // Pick the first candidate at or after the RR pointer.
  always_comb begin
    cand = ~fifo_empty;
`ifdef RV_ALU_SCHED_BR_PRIO_EN
    br_head = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      br_head[i] = cand[i] & is_branch(fifo_head[i].ap);
    end
    if (|br_head) begin
      cand = br_head;
    end
`endif
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    idx_l     = '0;
    for (int off = 0; off < int'(NREQ); off++) begin
      idx = int'(rr_q) + off;
      if (idx >= int'(NREQ)) begin
        idx = idx - int'(NREQ);
      end
      idx_l = IdxW'(idx);
      if (!grant_vld && cand[idx_l]) begin
        grant_vld = 1'b1;
        grant_idx = idx_l;
      end
    end
  end

  assign issue    = grant_vld & ~freeze & ~flush;
  assign head_sel = fifo_head[grant_idx];

  // Issue port; operands forced to 0 when nothing issues.
  always_comb begin
    alu_valid  = issue;
    alu_enable = issue;
    alu_a      = '0;
    alu_b      = '0;
    alu_pc     = '0;
    alu_brimm  = '0;
    alu_ap     = '0;
    if (issue) begin
      alu_a     = head_sel.a;
      alu_b     = head_sel.b;
      alu_pc    = head_sel.pc;
      alu_brimm = head_sel.brimm;
      alu_ap    = head_sel.ap;
    end
  end

  // RR pointer and in-flight owner next state; freeze holds, flush kills in-flight.
  always_comb begin
    rr_d      = rr_q;
    inf_vld_d = inf_vld_q;
    owner_d   = owner_q;
    if (issue) begin
      rr_d = (grant_idx == IdxW'(NREQ - 1)) ? '0 : grant_idx + IdxW'(1);
    end
    if (flush) begin
      inf_vld_d = 1'b0;
    end else if (!freeze) begin
      inf_vld_d = issue;
      if (issue) begin
        owner_d = grant_idx;
      end
    end
  end

  // Scheduler state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q      <= '0;
      inf_vld_q <= 1'b0;
      owner_q   <= '0;
    end else begin
      rr_q      <= rr_d;
      inf_vld_q <= inf_vld_d;
      owner_q   <= owner_d;
    end
  end

  assign rsp_fire = inf_vld_q & ~freeze & ~flush;

  // Route the ALU result back to the in-flight owner.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    rsp_flush = 1'b0;
    if (rsp_fire) begin
      rsp_valid[owner_q] = 1'b1;
      rsp_data           = alu_out;
      rsp_flush          = alu_flush_upper;
    end
  end

endmodule

// File: tb/tb_exu_alu_sched.sv
// Directed bench for exu_alu_sched (NREQ=2, DEPTH=2). Expected issues and responses
// are queued as stimulus is driven and consumed by a negedge monitor. A tiny ALU
// model (a+b, flush_upper=beq) closes the loop.
module tb_exu_alu_sched;
  import swerv_types::*;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned DEPTH = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  freeze = 1'b0;
  logic                  flush = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][31:0] req_a = '0;
  logic [NREQ-1:0][31:0] req_b = '0;
  logic [NREQ-1:0][31:1] req_pc = '0;
  logic [NREQ-1:0][12:1] req_brimm = '0;
  alu_pkt_t [NREQ-1:0]   req_ap = '0;
  logic                  alu_valid, alu_enable;
  logic [31:0]           alu_a, alu_b;
  logic [31:1]           alu_pc;
  logic [12:1]           alu_brimm;
  alu_pkt_t              alu_ap;
  logic [31:0]           alu_out = '0;
  logic                  alu_flush_upper = 1'b0;
  logic [NREQ-1:0]       rsp_valid;
  logic [31:0]           rsp_data;
  logic                  rsp_flush;

  exu_alu_sched #(
    .NREQ  (NREQ),
    .DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .freeze          (freeze),
    .flush           (flush),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_a           (req_a),
    .req_b           (req_b),
    .req_pc          (req_pc),
    .req_brimm       (req_brimm),
    .req_ap          (req_ap),
    .alu_valid       (alu_valid),
    .alu_enable      (alu_enable),
    .alu_a           (alu_a),
    .alu_b           (alu_b),
    .alu_pc          (alu_pc),
    .alu_brimm       (alu_brimm),
    .alu_ap          (alu_ap),
    .alu_out         (alu_out),
    .alu_flush_upper (alu_flush_upper),
    .rsp_valid       (rsp_valid),
    .rsp_data        (rsp_data),
    .rsp_flush       (rsp_flush)
  );

  always #5 clk = ~clk;

  // ALU model: result lands the cycle after issue, held while not enabled.
  always @(posedge clk) begin
    if (alu_enable) begin
      alu_out         <= alu_a + alu_b;
      alu_flush_upper <= alu_ap.beq;
    end
  end

  typedef struct {
    int unsigned req;
    logic [31:0] a;
    logic [31:0] b;
  } iss_t;

  typedef struct {
    int unsigned req;
    logic [31:0] data;
    logic        fl;
  } rsp_t;

  iss_t exp_iss[$];
  rsp_t exp_rsp[$];
  iss_t mon_i;
  rsp_t mon_r;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int unsigned r, input logic [31:0] a, input logic [31:0] b,
                       input logic br);
    req_valid[r]  = 1'b1;
    req_a[r]      = a;
    req_b[r]      = b;
    req_pc[r]     = a[31:1];
    req_brimm[r]  = b[12:1];
    req_ap[r]     = '0;
    req_ap[r].add = ~br;
    req_ap[r].beq = br;
  endtask

  task automatic exp_op(input int unsigned r, input logic [31:0] a, input logic [31:0] b,
                        input logic br, input logic with_rsp);
    exp_iss.push_back('{req: r, a: a, b: b});
    if (with_rsp) begin
      exp_rsp.push_back('{req: r, data: a + b, fl: br});
    end
  endtask

  task automatic chk_drain(input string tag);
    chk(tag, 32'(exp_iss.size() + exp_rsp.size()), 32'd0);
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (alu_valid) begin
      chk("iss_expected", 32'(exp_iss.size() != 0), 32'd1);
      chk("alu_enable", 32'(alu_enable), 32'd1);
      if (exp_iss.size() != 0) begin
        mon_i = exp_iss.pop_front();
        chk("iss_a", alu_a, mon_i.a);
        chk("iss_b", alu_b, mon_i.b);
        chk("iss_pc", 32'(alu_pc), 32'(mon_i.a[31:1]));
      end
    end
    if (rsp_valid != '0) begin
      chk("rsp_expected", 32'(exp_rsp.size() != 0), 32'd1);
      if (exp_rsp.size() != 0) begin
        mon_r = exp_rsp.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'd1 << mon_r.req);
        chk("rsp_data", rsp_data, mon_r.data);
        chk("rsp_flush", 32'(rsp_flush), 32'(mon_r.fl));
      end
    end
  end

  initial begin
    // Reset state.
    #2;
    chk("rst_ready", 32'(req_ready), 32'h3);
    chk("rst_alu_valid", 32'(alu_valid), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: both FIFOs loaded under freeze, then alternating issue r0,r1,r0,r1.
    tick(); freeze = 1'b1; req_valid = '0;
    drive(0, 32'h1000_0001, 32'h11, 1'b0);
    drive(1, 32'h2000_0001, 32'h22, 1'b0);
    tick(); req_valid = '0;
    drive(0, 32'h1000_0002, 32'h33, 1'b0);
    drive(1, 32'h2000_0002, 32'h44, 1'b0);
    tick(); req_valid = '0;
    chk("t1_full_ready", 32'(req_ready), 32'h0);
    exp_op(0, 32'h1000_0001, 32'h11, 1'b0, 1'b1);
    exp_op(1, 32'h2000_0001, 32'h22, 1'b0, 1'b1);
    exp_op(0, 32'h1000_0002, 32'h33, 1'b0, 1'b1);
    exp_op(1, 32'h2000_0002, 32'h44, 1'b0, 1'b1);
    freeze = 1'b0;
    repeat (6) tick();
    chk_drain("t1_drain");
    chk("t1_ready_back", 32'(req_ready), 32'h3);

    // 2: r0 full rejects a third push; ready returns once a pop has registered.
    tick(); freeze = 1'b1; req_valid = '0;
    drive(0, 32'h3000_0001, 32'h55, 1'b0);
    tick(); req_valid = '0;
    drive(0, 32'h3000_0002, 32'h66, 1'b0);
    tick(); req_valid = '0;
    drive(0, 32'hBAD0_0BAD, 32'h77, 1'b0);
    chk("t2_full_not_ready", 32'(req_ready[0]), 32'd0);
    tick(); req_valid = '0; freeze = 1'b0;
    exp_op(0, 32'h3000_0001, 32'h55, 1'b0, 1'b1);
    exp_op(0, 32'h3000_0002, 32'h66, 1'b0, 1'b1);
    chk("t2_still_full", 32'(req_ready[0]), 32'd0);
    tick();
    chk("t2_ready_after_pop", 32'(req_ready[0]), 32'd1);
    repeat (3) tick();
    chk_drain("t2_drain");

    // 3: r1 op issued, 3 frozen cycles hold the response.
    tick(); req_valid = '0;
    drive(1, 32'h4000_0001, 32'h88, 1'b0);
    exp_op(1, 32'h4000_0001, 32'h88, 1'b0, 1'b1);
    tick(); req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      tick(); freeze = 1'b1;
      #1;
      chk("t3_frozen_rsp", 32'(rsp_valid), 32'd0);
    end
    tick(); freeze = 1'b0;
    #1;
    chk("t3_unfrozen_rsp", 32'(rsp_valid), 32'h2);
    chk("t3_unfrozen_data", rsp_data, 32'h4000_0001 + 32'h88);
    repeat (2) tick();
    chk_drain("t3_drain");

    // 4: flush with 3 queued, 1 in flight, and a same-cycle enqueue.
    tick(); freeze = 1'b1; req_valid = '0;
    drive(0, 32'h5000_0001, 32'h1, 1'b0);
    drive(1, 32'h5000_0003, 32'h3, 1'b0);
    tick(); req_valid = '0;
    drive(0, 32'h5000_0002, 32'h2, 1'b0);
    drive(1, 32'h5000_0004, 32'h4, 1'b0);
    tick(); req_valid = '0; freeze = 1'b0;
    exp_op(0, 32'h5000_0001, 32'h1, 1'b0, 1'b0);
    tick(); flush = 1'b1;
    drive(0, 32'h5000_0005, 32'h5, 1'b0);
    drive(1, 32'h5000_0006, 32'h6, 1'b0);
    #1;
    chk("t4_flush_alu_valid", 32'(alu_valid), 32'd0);
    chk("t4_flush_rsp_valid", 32'(rsp_valid), 32'd0);
    tick(); flush = 1'b0; req_valid = '0;
    #1;
    chk("t4_post_alu_valid", 32'(alu_valid), 32'd0);
    chk("t4_post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t4_post_ready", 32'(req_ready), 32'h3);
    tick();
    chk("t4_no_flush_enq", 32'(alu_valid), 32'd0);
    chk_drain("t4_drain");

    // 5: async reset between edges; pointer returns to 0.
    tick(); freeze = 1'b1; req_valid = '0;
    drive(0, 32'h6000_0001, 32'h10, 1'b0);
    drive(1, 32'h6000_0011, 32'h20, 1'b0);
    tick(); req_valid = '0;
    drive(0, 32'h6000_0002, 32'h30, 1'b0);
    tick(); req_valid = '0; freeze = 1'b0;
    exp_op(1, 32'h6000_0011, 32'h20, 1'b0, 1'b1);
    tick();
    exp_op(0, 32'h6000_0001, 32'h10, 1'b0, 1'b0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_alu_valid", 32'(alu_valid), 32'd0);
    chk("t5_rst_alu_a", alu_a, 32'd0);
    chk("t5_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_rst_rsp_data", rsp_data, 32'd0);
    chk("t5_rst_ready", 32'(req_ready), 32'h3);
    tick();
    rst = 1'b0;
    tick(); freeze = 1'b1; req_valid = '0;
    drive(0, 32'h7000_0001, 32'h1, 1'b0);
    drive(1, 32'h7000_0002, 32'h2, 1'b0);
    tick(); req_valid = '0; freeze = 1'b0;
    exp_op(0, 32'h7000_0001, 32'h1, 1'b0, 1'b1);
    exp_op(1, 32'h7000_0002, 32'h2, 1'b0, 1'b1);
    repeat (4) tick();
    chk_drain("t5_drain");

    // 6: r0 head add, r1 head beq, pointer at 0.
    tick(); freeze = 1'b1; req_valid = '0;
    drive(0, 32'h8000_0001, 32'h5, 1'b0);
    drive(1, 32'h8000_0002, 32'h6, 1'b1);
    tick(); req_valid = '0; freeze = 1'b0;
`ifdef RV_ALU_SCHED_BR_PRIO_EN
    exp_op(1, 32'h8000_0002, 32'h6, 1'b1, 1'b1);
    exp_op(0, 32'h8000_0001, 32'h5, 1'b0, 1'b1);
`else
    exp_op(0, 32'h8000_0001, 32'h5, 1'b0, 1'b1);
    exp_op(1, 32'h8000_0002, 32'h6, 1'b1, 1'b1);
`endif
    repeat (4) tick();
    chk_drain("t6_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
